// File: rtl/sparse_idx_mask.sv
// ============================================================================
// sparse_idx_mask: accumulates a tile of sparse indices into a DEPTH-bit
// occupancy bitmap plus running count, handed off over valid/ready.
// Optional error flags: define SPARSE_ERR_CHK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sparse_idx_mask #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idx_valid,
  output logic              idx_ready,
  input  logic [ADDR_W-1:0] idx_data,
  input  logic              idx_last,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic [DEPTH-1:0]  mask_data,
  output logic [ADDR_W:0]   mask_count,
  output logic              err_dup,
  output logic              err_range
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  mask_q, mask_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic              w_accept;
  logic              w_handoff;
  logic              w_in_range;
  logic              w_hit;
  logic [DEPTH-1:0]  w_onehot;

  assign w_accept   = idx_valid && (state_q == ACCUM);
  assign w_handoff  = mask_ready && (state_q == HOLD);
  assign w_in_range = ({1'b0, idx_data} < C_DEPTH);
  // Indices past the top bit shift out entirely, so the decode is zero for them.
  assign w_onehot   = DEPTH'(1) << idx_data;
  assign w_hit      = |(mask_q & w_onehot);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    case (state_q)
      ACCUM: begin
        if (w_accept) begin
          if (w_in_range && !w_hit) begin
            mask_d  = mask_q | w_onehot;
            count_d = count_q + (ADDR_W+1)'(1);
          end
          if (idx_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_handoff) begin
          state_d = ACCUM;
          mask_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign idx_ready  = (state_q == ACCUM);
  assign mask_valid = (state_q == HOLD);
  assign mask_data  = mask_q;
  assign mask_count = count_q;

`ifdef SPARSE_ERR_CHK_EN
  logic dup_q, dup_d;
  logic range_q, range_d;

  always_comb begin
    dup_d   = dup_q;
    range_d = range_q;
    if (w_handoff) begin
      dup_d   = 1'b0;
      range_d = 1'b0;
    end else if (w_accept) begin
      if (!w_in_range) begin
        range_d = 1'b1;
      end else if (w_hit) begin
        dup_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_q   <= 1'b0;
      range_q <= 1'b0;
    end else begin
      dup_q   <= dup_d;
      range_q <= range_d;
    end
  end

  assign err_dup   = dup_q;
  assign err_range = range_q;
`else
  assign err_dup   = 1'b0;
  assign err_range = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sparse_idx_mask.sv
// Bench for sparse_idx_mask: two instances (DEPTH=128 and DEPTH=100) share one
// index stream; each is compared with an associative-array model of the tile.
`timescale 1ns/1ps
`default_nettype none

module tb_sparse_idx_mask;

  localparam int AW = 7;
  localparam int DA = 128;
  localparam int DB = 100;
`ifdef SPARSE_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          idx_valid  = 1'b0;
  logic          idx_last   = 1'b0;
  logic          mask_ready = 1'b0;
  logic [AW-1:0] idx_data   = '0;

  logic          a_idx_ready, a_mask_valid, a_err_dup, a_err_range;
  logic [DA-1:0] a_mask_data;
  logic [AW:0]   a_mask_count;
  logic          b_idx_ready, b_mask_valid, b_err_dup, b_err_range;
  logic [DB-1:0] b_mask_data;
  logic [AW:0]   b_mask_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sparse_idx_mask #(.ADDR_W(AW), .DEPTH(DA)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_valid  (idx_valid),
    .idx_ready  (a_idx_ready),
    .idx_data   (idx_data),
    .idx_last   (idx_last),
    .mask_valid (a_mask_valid),
    .mask_ready (mask_ready),
    .mask_data  (a_mask_data),
    .mask_count (a_mask_count),
    .err_dup    (a_err_dup),
    .err_range  (a_err_range)
  );

  sparse_idx_mask #(.ADDR_W(AW), .DEPTH(DB)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_valid  (idx_valid),
    .idx_ready  (b_idx_ready),
    .idx_data   (idx_data),
    .idx_last   (idx_last),
    .mask_valid (b_mask_valid),
    .mask_ready (mask_ready),
    .mask_data  (b_mask_data),
    .mask_count (b_mask_count),
    .err_dup    (b_err_dup),
    .err_range  (b_err_range)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: set of distinct in-range indices, with repeat and range flags.
  task automatic model_tile(input int q[$], input int depth, output logic [127:0] m,
                            output logic [AW:0] cnt, output logic dup, output logic rng);
    int occ[int];
    m   = '0;
    dup = 1'b0;
    rng = 1'b0;
    foreach (q[i]) begin
      if (q[i] >= depth) rng = 1'b1;
      else if (occ.exists(q[i])) begin
        dup = 1'b1;
        occ[q[i]] = occ[q[i]] + 1;
      end else occ[q[i]] = 1;
    end
    foreach (occ[k]) m[k] = 1'b1;
    cnt = (AW+1)'(occ.num());
  endtask

  // Feeds one tile with random gaps, then holds the result for 'hold' cycles
  // with junk beats offered, then hands off and checks the clear.
  task automatic run_tile(input string name, input int q[$], input int hold);
    logic [127:0] ma, mb;
    logic [AW:0]  ca, cb;
    logic         da, ra, db, rb;
    logic [139:0] ea, ga;
    logic [111:0] eb, gb;
    model_tile(q, DA, ma, ca, da, ra);
    model_tile(q, DB, mb, cb, db, rb);
    foreach (q[i]) begin
      repeat ($urandom_range(0, 2)) begin
        idx_valid = 1'b0;
        idx_data  = AW'($urandom);
        idx_last  = 1'($urandom);
        @(negedge clk);
      end
      idx_valid = 1'b1;
      idx_data  = AW'(q[i]);
      idx_last  = (i == q.size() - 1);
      n_cmp++;
      if ({a_idx_ready, a_mask_valid, b_idx_ready, b_mask_valid} !== 4'b1010) begin
        n_fail++;
        $display("FAIL %s beat%0d ready/valid: got %b want 1010", name, i,
                 {a_idx_ready, a_mask_valid, b_idx_ready, b_mask_valid});
      end
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      idx_valid  = 1'($urandom);
      idx_data   = AW'($urandom);
      idx_last   = 1'($urandom);
      mask_ready = (h == hold);
      ea = {1'b1, 1'b0, ca, da & ERR_EN, ra & ERR_EN, ma};
      ga = {a_mask_valid, a_idx_ready, a_mask_count, a_err_dup, a_err_range, a_mask_data};
      eb = {1'b1, 1'b0, cb, db & ERR_EN, rb & ERR_EN, mb[DB-1:0]};
      gb = {b_mask_valid, b_idx_ready, b_mask_count, b_err_dup, b_err_range, b_mask_data};
      n_cmp++;
      if (ga !== ea) begin
        n_fail++;
        $display("FAIL %s dutA hold%0d: got %h want %h", name, h, ga, ea);
      end
      n_cmp++;
      if (gb !== eb) begin
        n_fail++;
        $display("FAIL %s dutB hold%0d: got %h want %h", name, h, gb, eb);
      end
      @(negedge clk);
    end
    mask_ready = 1'b0;
    idx_valid  = 1'b0;
    ga = {a_mask_valid, a_idx_ready, a_mask_count, a_err_dup, a_err_range, a_mask_data};
    gb = {b_mask_valid, b_idx_ready, b_mask_count, b_err_dup, b_err_range, b_mask_data};
    n_cmp++;
    if (ga !== {2'b01, 138'b0}) begin
      n_fail++;
      $display("FAIL %s dutA clear: got %h want %h", name, ga, {2'b01, 138'b0});
    end
    n_cmp++;
    if (gb !== {2'b01, 110'b0}) begin
      n_fail++;
      $display("FAIL %s dutB clear: got %h want %h", name, gb, {2'b01, 110'b0});
    end
  endtask

  task automatic test_reset();
    logic [139:0] ga;
    logic [111:0] gb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ga = {a_mask_valid, a_idx_ready, a_mask_count, a_err_dup, a_err_range, a_mask_data};
    gb = {b_mask_valid, b_idx_ready, b_mask_count, b_err_dup, b_err_range, b_mask_data};
    n_cmp++;
    if (ga !== {2'b01, 138'b0}) begin
      n_fail++;
      $display("FAIL reset dutA: got %h want %h", ga, {2'b01, 138'b0});
    end
    n_cmp++;
    if (gb !== {2'b01, 110'b0}) begin
      n_fail++;
      $display("FAIL reset dutB: got %h want %h", gb, {2'b01, 110'b0});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int q[$];
    q = '{0, 5, 127};
    run_tile("basic", q, 0);
  endtask

  task automatic test_dup();
    int q[$];
    q = '{9, 9, 9};
    run_tile("dup", q, 2);
  endtask

  task automatic test_range();
    int q[$];
    q = '{99, 100, 127};
    run_tile("range", q, 1);
    q = '{120};
    run_tile("empty", q, 1);
    q = '{7, 7};
    run_tile("dup_tail", q, 0);
  endtask

  task automatic test_backpressure();
    int q[$];
    int j, t;
    for (int i = 0; i < 128; i++) q.push_back(i);
    for (int i = 127; i > 0; i--) begin
      j    = int'($urandom_range(0, i));
      t    = q[i];
      q[i] = q[j];
      q[j] = t;
    end
    run_tile("full_tile", q, 10);
    q = '{3};
    run_tile("after_full", q, 0);
  endtask

  task automatic test_reset_mid();
    logic [139:0] ga;
    logic [111:0] gb;
    int q[$];
    idx_valid = 1'b1;
    idx_data  = AW'(1);
    idx_last  = 1'b0;
    @(negedge clk);
    idx_data = AW'(2);
    n_cmp++;
    if ({a_mask_count, a_mask_data} !== {8'd1, 128'h2}) begin
      n_fail++;
      $display("FAIL mid_bit1: got cnt %0d data %h want cnt 1 data 2", a_mask_count, a_mask_data);
    end
    @(negedge clk);
    idx_valid = 1'b0;
    n_cmp++;
    if ({a_mask_count, a_mask_data} !== {8'd2, 128'h6}) begin
      n_fail++;
      $display("FAIL mid_bit2: got cnt %0d data %h want cnt 2 data 6", a_mask_count, a_mask_data);
    end
    #2 rst_n = 1'b0;
    #1;
    ga = {a_mask_valid, a_idx_ready, a_mask_count, a_err_dup, a_err_range, a_mask_data};
    gb = {b_mask_valid, b_idx_ready, b_mask_count, b_err_dup, b_err_range, b_mask_data};
    n_cmp++;
    if (ga !== {2'b01, 138'b0}) begin
      n_fail++;
      $display("FAIL async_reset dutA: got %h want %h", ga, {2'b01, 138'b0});
    end
    n_cmp++;
    if (gb !== {2'b01, 110'b0}) begin
      n_fail++;
      $display("FAIL async_reset dutB: got %h want %h", gb, {2'b01, 110'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{4};
    run_tile("reset_mid", q, 1);
  endtask

  task automatic test_random();
    int q[$];
    int n;
    for (int t = 0; t < 20; t++) begin
      q.delete();
      n = int'($urandom_range(1, 40));
      for (int k = 0; k < n; k++) begin
        if (k > 0 && $urandom_range(0, 5) == 0) q.push_back(q[$urandom_range(0, k - 1)]);
        else q.push_back(int'($urandom_range(0, 127)));
      end
      run_tile($sformatf("random%0d", t), q, int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
